fltr_sched: RTL and testbench

FLTR_SCHED -- requirements
Module: fltr_sched

---
 rtl/fltr_pkg.sv | 14 +
 rtl/fltr_core.sv | 33 +++
 rtl/fltr_sched.sv | 98 +++++++++
 tb/tb_fltr_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fltr_pkg.sv
// Shared types and default constants for the round-robin debounce filter scheduler.
package fltr_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int THRESH_DEF = 3;
  localparam int CNT_W_DEF  = 4;

  typedef logic [$clog2(N_CH_DEF)-1:0] ch_idx_t;
  typedef logic [CNT_W_DEF-1:0]        cnt_t;
  typedef logic [15:0]                 stat_t;

  localparam stat_t STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fltr_core.sv
// Per-sample debounce rule for one channel context. This block is purely combinational
// and is shared by all channels through the scheduler's context mux.
module fltr_core #(
  parameter int CNT_W  = 4,
  parameter int THRESH = 3
) (
  input  logic             sample,
  input  logic             out_cur,
  input  logic [CNT_W-1:0] cnt_cur,
  output logic             out_nxt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             flip
);

  logic [CNT_W:0] cnt_inc;

  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    out_nxt = out_cur;
    cnt_nxt = '0;
    flip    = 1'b0;
    cnt_inc = {1'b0, cnt_cur} + (CNT_W+1)'(1);
    if (sample != out_cur) begin
      if (cnt_inc == (CNT_W+1)'(THRESH)) begin
        out_nxt = sample;
        flip    = 1'b1;
      end else begin
        cnt_nxt = cnt_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fltr_sched.sv
// Round-robin scheduler time-sharing one fltr_core over N_CH channel contexts.
// Optional per-channel flip statistics are enabled by defining FLTR_SCHED_STAT_EN.
module fltr_sched
  import fltr_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int THRESH = THRESH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int PW    = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] out_vld,
  output logic [PW-1:0]   cur_ch
`ifdef FLTR_SCHED_STAT_EN
  ,
  input  logic [PW-1:0]   stat_sel,
  output stat_t           stat_cnt
`endif
);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  out_q, out_d;
  logic [N_CH-1:0]  vld_q, vld_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic             core_out;
  logic [CNT_W-1:0] core_cnt;
  logic             core_flip;

  fltr_core #(.CNT_W(CNT_W), .THRESH(THRESH)) u_core (
    .sample  (in[ptr_q]),
    .out_cur (out_q[ptr_q]),
    .cnt_cur (cnt_q[ptr_q]),
    .out_nxt (core_out),
    .cnt_nxt (core_cnt),
    .flip    (core_flip)
  );

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    vld_d = '0;
    ptr_d = ptr_q;
    if (enable) begin
      cnt_d[ptr_q] = core_cnt;
      out_d[ptr_q] = core_out;
      vld_d[ptr_q] = 1'b1;
      ptr_d        = (ptr_q == PW'(N_CH-1)) ? '0 : ptr_q + PW'(1);
    end
  end

  // NOTE: the context array must be reset as a whole, so it maps to flops rather than RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      out_q <= '0;
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so all flops sample together.
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign out     = out_q;
  assign out_vld = vld_q;
  assign cur_ch  = ptr_q;

`ifdef FLTR_SCHED_STAT_EN
  stat_t stat_q [N_CH];
  stat_t stat_d [N_CH];

  always_comb begin
    stat_d = stat_q;
    if (enable && core_flip && stat_q[ptr_q] != STAT_MAX)
      stat_d[ptr_q] = stat_q[ptr_q] + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = (int'(stat_sel) < N_CH) ? stat_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_fltr_sched.sv
// Scoreboard bench for fltr_sched: a driver predicts each serviced edge from a
// behavioural model and queues the result; a monitor checks every out_vld pulse.
module tb_fltr_sched;

  localparam int N_CH   = 4;
  localparam int THRESH = 3;
  localparam int PW     = $clog2(N_CH);

  typedef struct packed {
    logic [N_CH-1:0] vld;
    logic [N_CH-1:0] out;
    logic [PW-1:0]   ptr;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [N_CH-1:0] in = '0;
  logic [N_CH-1:0] out, out_vld;
  logic [PW-1:0]   cur_ch;
`ifdef FLTR_SCHED_STAT_EN
  logic [PW-1:0]   stat_sel = '0;
  logic [15:0]     stat_cnt;
`endif

  fltr_sched #(.N_CH(N_CH), .THRESH(THRESH), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .in      (in),
    .out     (out),
    .out_vld (out_vld),
    .cur_ch  (cur_ch)
`ifdef FLTR_SCHED_STAT_EN
    ,
    .stat_sel(stat_sel),
    .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  // Behavioural reference: per-channel run length and output, pointer as an integer.
  int m_ptr;
  int m_run  [N_CH];
  bit m_out  [N_CH];
  int m_flips[N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] model_out_vec();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_out[i];
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_run[i] = 0; m_out[i] = 0; m_flips[i] = 0;
    end
    sb_q.delete();
  endtask

  // One clock of stimulus: drive at the falling edge, predict the coming rising edge.
  task automatic drive(input logic en, input logic [N_CH-1:0] iv);
    exp_t e;
    int p;
    @(negedge clk);
    enable = en;
    in     = iv;
`ifdef FLTR_SCHED_STAT_EN
    stat_sel = PW'($urandom_range(N_CH-1));
`endif
    if (en) begin
      p = m_ptr;
      if (iv[p] == m_out[p]) begin
        m_run[p] = 0;
      end else if (m_run[p] + 1 >= THRESH) begin
        m_out[p] = iv[p];
        m_run[p] = 0;
        m_flips[p]++;
      end else begin
        m_run[p]++;
      end
      m_ptr = (m_ptr + 1) % N_CH;
      e.vld = '0;
      e.vld[p] = 1'b1;
      e.out = model_out_vec();
      e.ptr = PW'(m_ptr);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: checks every valid pulse against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && out_vld != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_vld", 32'(out_vld), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("out_vld", 32'(out_vld), 32'(e.vld));
          check("out",     32'(out),     32'(e.out));
          check("cur_ch",  32'(cur_ch),  32'(e.ptr));
        end
      end
`ifdef FLTR_SCHED_STAT_EN
      if (!reset) check("stat_cnt", 32'(stat_cnt), 32'(m_flips[stat_sel] > 65535 ? 65535 : m_flips[stat_sel]));
`endif
    end
  end

  initial begin
    logic [N_CH-1:0] iv;
    model_reset();
    reset  = 1'b1;
    enable = 1'b1;
    in     = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_out", 32'(out), 32'h0);
      check("rst_vld", 32'(out_vld), 32'h0);
      check("rst_ptr", 32'(cur_ch), 32'h0);
    end

    // Single channel held high from release: ch0 flips on its third service (E8).
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 9; i++) drive(1'b1, 4'b0001);
    @(negedge clk);
    enable = 1'b0;
    check("e8_out", 32'(out), 32'h1);
    check("e8_vld", 32'(out_vld), 32'h1);

    // Asynchronous reset mid-count, observed without a clock edge.
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0010);
    @(negedge clk);
    enable = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_out", 32'(out), 32'h0);
    check("async_vld", 32'(out_vld), 32'h0);
    check("async_ptr", 32'(cur_ch), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // All channels high at once: flips walk across E8..E11.
    for (int i = 0; i < 12; i++) drive(1'b1, 4'hF);
    @(negedge clk);
    enable = 1'b0;
    check("all_out", 32'(out), 32'hF);

    // Random run: mostly-stable inputs, random stalls and rare resets.
    iv = in;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N_CH; b++)
        if ($urandom_range(5) == 0) iv[b] = ~iv[b];
      if ($urandom_range(400) == 0) begin
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        model_reset();
        @(negedge clk);
        check("rnd_rst_out", 32'(out), 32'h0);
        reset = 1'b0;
      end else begin
        drive($urandom_range(4) != 0, iv);
      end
    end

    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    check("final_out", 32'(out), 32'(model_out_vec()));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
